irq_req_latch: RTL and testbench
================================

# irq_req_latch

Request-capture front end for the 8:3 priority encoder. Synchronizes eight asynchronous request lines, detects rising edges, holds them as sticky pending bits, and offers the highest-index pending request as a 3-bit index over a valid/ready handshake. The granted pending bit is cleared on acceptance. The block drives the priority encoder's 8-bit input and registers its 3-bit output toward the consumer.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops per request line (minimum 2).
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_in`  in  8  asynchronous request lines; a rising edge raises a request.
- `grant_idx`  out  3  index of the offered request; stable while `grant_valid` is high.
- `grant_valid`  out  1  an offer is presented.
- `grant_ready`  in  1  consumer accepts the offer when high together with `grant_valid`.
- `pending`  out  8  current pending register, for status and debug.
- `lost`  out  1  one-cycle pulse when an edge arrives on a bit that is already pending.
- `mask_wr`  in  1  present only with `IRQ_MASK_EN`: load the mask register.
- `mask_wdata`  in  8  present only with `IRQ_MASK_EN`: new mask value; 1 = disabled.

## Operation
- Reset values:
  - All sync flops, edge-history flops, `pending` and mask are 0.
  - FSM is in IDLE.
  - `grant_idx` = 0, `grant_valid` = 0, `lost` = 0.
- Edge detect: `edge[i] = sync_out[i] & ~prev[i]`. `prev` resets to 0, so a line held high through reset release produces one request.
- Pending update, per bit, each cycle:
  - The bit is set by `edge[i]`.
  - The bit is cleared on accept (`grant_valid & grant_ready`) when `i == grant_idx`.
  - If set and clear hit the same bit in the same cycle, set wins and the bit stays 1.
- `lost` pulses when `edge[i] & pending[i]` for any i and that bit is not being cleared in the same cycle.
- Eligible vector: `pending & ~mask`. Without `IRQ_MASK_EN` it is `pending`.
- Priority: the highest set index wins (bit 7 highest), matching the 8:3 encoder.
- FSM has two states:
  - IDLE: if eligible is nonzero, register `grant_idx = encode(eligible)`, set `grant_valid`, and go to OFFER. Otherwise stay.
  - OFFER: hold `grant_idx` and `grant_valid`. On `grant_ready`, clear `grant_valid` and return to IDLE.
- An offer is never retracted. A later higher-priority request or a mask change does not alter `grant_idx` until the current offer is accepted.
- `grant_ready` is ignored in IDLE.

## Timing
- Request latency:
  - `req_in[i]` first sampled high at edge k.
  - `pending[i]` reads 1 after edge k+SYNC_STAGES.
  - `grant_valid` rises after edge k+SYNC_STAGES+1; this is 3 cycles at the default `SYNC_STAGES`.
- Accept at edge a: `pending` bit reads 0 and `grant_valid` reads 0 after edge a. The next offer can appear after edge a+1.
- Maximum throughput is one grant per 2 cycles.
- `grant_ready` may be held high permanently. Each offer is then accepted exactly one cycle after it appears.
- Asserting `rst_n` low mid-offer drops `grant_valid` immediately (asynchronously) and discards all pending bits.
- Mask write at edge m takes effect for the IDLE decision at edge m+1.

## Configuration
- `IRQ_MASK_EN` defined:
  - Adds the mask register and the `mask_wr`/`mask_wdata` ports.
  - Masked bits still latch as pending but are never offered.
  - Unmasking a pending bit makes it eligible.
- `IRQ_MASK_EN` undefined: no mask register and no mask ports; every pending bit is eligible.

## Structure
- Shared package `irq_pkg` holds:
  - `IRQ_N = 8` and `IRQ_IDX_W = 3`.
  - The FSM state encoding: IDLE = 0, OFFER = 1.
- Sub-module `pri_enc8`: combinational 8:3 priority encoder with a `valid` output. It is instantiated once on the eligible vector. The FSM uses its `valid` output for the IDLE decision.

## Test plan
- Reset, then pulse `req_in = 8'h04` for 1 cycle -> `grant_valid` rises 3 cycles after sampling with `grant_idx = 2`. With `grant_ready = 1` it is accepted, and `pending` returns to `8'h00`.
- Edges on `req_in = 8'h81` in the same cycle, `grant_ready` held high -> grants 7 then 0, two cycles apart, then `grant_valid` stays 0.
- Hold `grant_ready = 0` during an offer of index 3, then raise bit 6 -> `grant_idx` stays 3 until accepted. Index 6 is offered next.
- Second rising edge on bit 5 while `pending[5] = 1` -> `lost` pulses for one cycle and `pending` is unchanged.
- Edge on bit 4 arriving in the same cycle its grant is accepted -> `pending[4]` stays 1 and is re-offered, with no `lost` pulse.
- With `IRQ_MASK_EN`: mask `8'h80`, then edges on bits 7 and 1 -> only index 1 is granted. Writing mask `8'h00` -> index 7 is granted next. Separately, asserting `rst_n` low mid-offer -> `grant_valid` drops to 0 immediately and `pending` reads 0.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt request-capture front end:
// request width, index width, offer FSM encoding and an index decoder.
package irq_pkg;

    localparam int IRQ_N     = 8;
    localparam int IRQ_IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } irq_state_e;

    // One-hot vector with only the bit selected by idx set.
    function automatic logic [IRQ_N-1:0] idx_onehot(input logic [IRQ_IDX_W-1:0] idx);
        logic [IRQ_N-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/pri_enc8.sv
// Combinational 8:3 priority encoder. The highest set input index wins;
// valid flags that at least one input is set (idx is 0 otherwise).
module pri_enc8
    import irq_pkg::*;
(
    input  logic [IRQ_N-1:0]     req,
    output logic [IRQ_IDX_W-1:0] idx,
    output logic                 valid
);

    // Scan upward so the last (highest) set bit overrides lower ones.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < IRQ_N; i++) begin
            if (req[i]) begin
                idx   = IRQ_IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_req_latch.sv
// Request-capture front end for the 8:3 priority encoder.
// Synchronizes eight asynchronous request lines, turns rising edges into
// sticky pending bits and offers the highest pending index over a
// valid/ready handshake. An accepted offer clears its pending bit.
// Optional feature: define IRQ_MASK_EN to add a per-bit mask register
// (mask_wr / mask_wdata, 1 = disabled). Masked bits still latch as pending
// but are never offered.
module irq_req_latch
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2    // must be at least 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IRQ_N-1:0]     req_in,
    output logic [IRQ_IDX_W-1:0] grant_idx,
    output logic                 grant_valid,
    input  logic                 grant_ready,
`ifdef IRQ_MASK_EN
    input  logic                 mask_wr,
    input  logic [IRQ_N-1:0]     mask_wdata,
`endif
    output logic [IRQ_N-1:0]     pending,
    output logic                 lost
);

    logic [IRQ_N-1:0]     sync_p [SYNC_STAGES];
    logic [IRQ_N-1:0]     sync_out;
    logic [IRQ_N-1:0]     req_prev;
    logic [IRQ_N-1:0]     req_edge;
    logic [IRQ_N-1:0]     clr_vec;
    logic [IRQ_N-1:0]     eligible;
    logic [IRQ_IDX_W-1:0] enc_idx;
    logic                 enc_valid;
    irq_state_e           state;

    // ---- Stage: synchronizer chain, one flop row per stage ----
    // Shift each request line through SYNC_STAGES flops to tame metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_p[s] <= '0;
            end
        end else begin
            sync_p[0] <= req_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_p[s] <= sync_p[s-1];
            end
        end
    end

    assign sync_out = sync_p[SYNC_STAGES-1];

    // ---- Stage: edge detect and pending capture ----
    // prev resets to 0, so a line already high at reset release yields one edge.
    assign req_edge = sync_out & ~req_prev;

    // Bit to clear when the current offer is taken this cycle.
    assign clr_vec = (grant_valid && grant_ready) ? idx_onehot(grant_idx) : '0;

    // Track history, latch edges into pending (set beats clear) and flag
    // edges that land on a bit that is already pending and staying pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_prev <= '0;
            pending  <= '0;
            lost     <= 1'b0;
        end else begin
            req_prev <= sync_out;
            pending  <= (pending & ~clr_vec) | req_edge;
            lost     <= |(req_edge & pending & ~clr_vec);
        end
    end

`ifdef IRQ_MASK_EN
    logic [IRQ_N-1:0] mask_q;

    // Mask register; a write is visible to the offer decision one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else if (mask_wr) begin
            mask_q <= mask_wdata;
        end
    end

    assign eligible = pending & ~mask_q;
`else
    assign eligible = pending;
`endif

    pri_enc8 u_pri_enc8 (
        .req   (eligible),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    // ---- Stage: offer FSM with registered grant outputs ----
    // An offer is held unchanged until accepted; ready is ignored in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enc_valid) begin
                        grant_idx   <= enc_idx;
                        grant_valid <= 1'b1;
                        state       <= OFFER;
                    end
                end
                OFFER: begin
                    if (grant_ready) begin
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    grant_valid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_req_latch.sv
// Directed bench for irq_req_latch: a cycle-by-cycle vector table plus
// hand-written sequences for asynchronous reset mid-offer and (when
// IRQ_MASK_EN is defined) the mask register.
module tb_irq_req_latch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       rdy;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic [7:0] pending;
    logic       lost;
`ifdef IRQ_MASK_EN
    logic       mask_wr;
    logic [7:0] mask_wdata;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    irq_req_latch #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_in      (req),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .grant_ready (rdy),
`ifdef IRQ_MASK_EN
        .mask_wr     (mask_wr),
        .mask_wdata  (mask_wdata),
`endif
        .pending     (pending),
        .lost        (lost)
    );

    typedef struct {
        logic [7:0] req;
        logic       rdy;
        logic       exp_v;
        logic [2:0] exp_idx;
        logic [7:0] exp_p;
        logic       exp_lost;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic [7:0] r, input logic y, input logic v,
                        input logic [2:0] i, input logic [7:0] p, input logic l);
        vec_t t;
        t.req = r; t.rdy = y; t.exp_v = v; t.exp_idx = i; t.exp_p = p; t.exp_lost = l;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!grant_valid && n < 10) begin
            step();
            n++;
        end
        chk(name, 32'(grant_valid), 32'd1);
    endtask

    initial begin
        // req rdy | valid idx pending lost  (state after the clock edge)
        // single request on bit 2
        addv(8'h04,1, 0,0,8'h00,0); addv(8'h00,1, 0,0,8'h00,0);
        addv(8'h00,1, 0,0,8'h04,0); addv(8'h00,1, 1,2,8'h04,0);
        addv(8'h00,1, 0,2,8'h00,0); addv(8'h00,1, 0,2,8'h00,0);
        // simultaneous bits 7 and 0, ready held high
        addv(8'h81,1, 0,2,8'h00,0); addv(8'h00,1, 0,2,8'h00,0);
        addv(8'h00,1, 0,2,8'h81,0); addv(8'h00,1, 1,7,8'h81,0);
        addv(8'h00,1, 0,7,8'h01,0); addv(8'h00,1, 1,0,8'h01,0);
        addv(8'h00,1, 0,0,8'h00,0); addv(8'h00,1, 0,0,8'h00,0);
        // second edge on pending bit 5 -> lost pulse
        addv(8'h20,0, 0,0,8'h00,0); addv(8'h20,0, 0,0,8'h00,0);
        addv(8'h00,0, 0,0,8'h20,0); addv(8'h00,0, 1,5,8'h20,0);
        addv(8'h20,0, 1,5,8'h20,0); addv(8'h00,0, 1,5,8'h20,0);
        addv(8'h00,0, 1,5,8'h20,1); addv(8'h00,0, 1,5,8'h20,0);
        addv(8'h00,1, 0,5,8'h00,0); addv(8'h00,1, 0,5,8'h00,0);
        // offer of 3 held while bit 6 arrives
        addv(8'h08,0, 0,5,8'h00,0); addv(8'h00,0, 0,5,8'h00,0);
        addv(8'h00,0, 0,5,8'h08,0); addv(8'h00,0, 1,3,8'h08,0);
        addv(8'h40,0, 1,3,8'h08,0); addv(8'h00,0, 1,3,8'h08,0);
        addv(8'h00,0, 1,3,8'h48,0); addv(8'h00,0, 1,3,8'h48,0);
        addv(8'h00,1, 0,3,8'h40,0); addv(8'h00,1, 1,6,8'h40,0);
        addv(8'h00,1, 0,6,8'h00,0); addv(8'h00,0, 0,6,8'h00,0);
        // edge on bit 4 in the same cycle its grant is accepted
        addv(8'h10,0, 0,6,8'h00,0); addv(8'h00,0, 0,6,8'h00,0);
        addv(8'h00,0, 0,6,8'h10,0); addv(8'h00,0, 1,4,8'h10,0);
        addv(8'h10,0, 1,4,8'h10,0); addv(8'h00,0, 1,4,8'h10,0);
        addv(8'h00,1, 0,4,8'h10,0); addv(8'h00,1, 1,4,8'h10,0);
        addv(8'h00,1, 0,4,8'h00,0); addv(8'h00,0, 0,4,8'h00,0);

        rst_n = 1'b0;
        req   = '0;
        rdy   = 1'b0;
`ifdef IRQ_MASK_EN
        mask_wr    = 1'b0;
        mask_wdata = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset grant_valid", 32'(grant_valid), 32'd0);
        chk("reset grant_idx",   32'(grant_idx),   32'd0);
        chk("reset pending",     32'(pending),     32'd0);
        chk("reset lost",        32'(lost),        32'd0);
        rst_n = 1'b1;

        foreach (vecs[r]) begin
            req = vecs[r].req;
            rdy = vecs[r].rdy;
            step();
            chk($sformatf("row%0d grant_valid", r), 32'(grant_valid), 32'(vecs[r].exp_v));
            chk($sformatf("row%0d grant_idx", r),   32'(grant_idx),   32'(vecs[r].exp_idx));
            chk($sformatf("row%0d pending", r),     32'(pending),     32'(vecs[r].exp_p));
            chk($sformatf("row%0d lost", r),        32'(lost),        32'(vecs[r].exp_lost));
        end

        // Asynchronous reset while an offer of index 1 is outstanding.
        rdy = 1'b0;
        req = 8'h02;
        step();
        req = 8'h00;
        wait_valid("rst seq offer appears");
        chk("rst seq offer idx", 32'(grant_idx), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst grant_valid", 32'(grant_valid), 32'd0);
        chk("async rst pending",     32'(pending),     32'd0);
        #2;
        rst_n = 1'b1;
        repeat (4) step();
        chk("post rst grant_valid", 32'(grant_valid), 32'd0);
        chk("post rst pending",     32'(pending),     32'd0);

`ifdef IRQ_MASK_EN
        // Mask bit 7, raise bits 7 and 1: only 1 is offered until unmasked.
        mask_wr    = 1'b1;
        mask_wdata = 8'h80;
        step();
        mask_wr = 1'b0;
        req = 8'h82;
        step();
        req = 8'h00;
        wait_valid("mask offer appears");
        chk("mask offer idx",     32'(grant_idx), 32'd1);
        chk("mask offer pending", 32'(pending),   32'h82);
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        chk("mask accept pending", 32'(pending), 32'h80);
        repeat (3) step();
        chk("masked bit not offered", 32'(grant_valid), 32'd0);
        mask_wr    = 1'b1;
        mask_wdata = 8'h00;
        step();
        mask_wr = 1'b0;
        chk("unmask write edge valid", 32'(grant_valid), 32'd0);
        step();
        chk("unmask offer valid", 32'(grant_valid), 32'd1);
        chk("unmask offer idx",   32'(grant_idx),   32'd7);
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        chk("unmask accept pending", 32'(pending), 32'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
